// File: rtl/md5_uart_top.sv
// md5_uart_rx: 8N1 receiver with 2-flop synchronizer and 8x phase-accumulator oversampling.
// Latency: rx_valid pulses about half a bit after the stop-bit edge (stop bit sampled at its centre).
// Backpressure: none; rx_valid is a 1-cycle strobe and framing-error bytes are dropped.
module md5_uart_rx #(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int BAUD          = 12_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic       rx_valid,
  output logic [7:0] rx_data
);
  // 32-bit fractional increment for an 8*BAUD oversample tick, rounded to nearest
  localparam logic [31:0] OSR_INC =
    32'((((64'(BAUD) * 64'd8) << 32) + 64'(CLK_FREQUENCY / 2)) / 64'(CLK_FREQUENCY));

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t   state_q, state_d;
  logic        rxd_meta, rxd_sync, rxd_prev;
  logic [31:0] acc_q;
  logic [32:0] acc_sum;
  logic        tick;
  logic        acc_clr;
  logic [2:0]  tcnt_q, tcnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        valid_d;

  assign acc_sum = {1'b0, acc_q} + {1'b0, OSR_INC};
  assign tick    = acc_sum[32];
  assign rx_data = shift_q;

  // Two-flop synchronizer plus one history flop for falling-edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
    end
  end

  // Oversample phase accumulator, re-phased on every detected start edge
  always_ff @(posedge clk) begin
    if (reset || acc_clr) acc_q <= '0;
    else                  acc_q <= acc_sum[31:0];
  end

  // Receiver state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RX_IDLE;
      tcnt_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      rx_valid <= 1'b0;
    end else begin
      state_q  <= state_d;
      tcnt_q   <= tcnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      rx_valid <= valid_d;
    end
  end

  // Receiver next-state: half-bit start re-check, then one sample every 8 ticks
  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    acc_clr = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (rxd_prev && !rxd_sync) begin
          state_d = RX_START;
          tcnt_d  = '0;
          acc_clr = 1'b1;
        end
      end
      RX_START: begin
        if (tick) begin
          tcnt_d = tcnt_q + 3'd1;
          if (tcnt_q == 3'd3) begin
            tcnt_d  = '0;
            bit_d   = '0;
            state_d = rxd_sync ? RX_IDLE : RX_DATA;
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          tcnt_d = tcnt_q + 3'd1;
          if (tcnt_q == 3'd7) begin
            shift_d = {rxd_sync, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = RX_STOP;
          end
        end
      end
      RX_STOP: begin
        if (tick) begin
          tcnt_d = tcnt_q + 3'd1;
          if (tcnt_q == 3'd7) begin
            valid_d = rxd_sync;
            state_d = RX_IDLE;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end
endmodule

// md5_uart_tx: 8N1 transmitter paced by a BAUD-rate phase accumulator restarted on accept.
// Latency: start bit appears on txd the cycle after accept; a frame lasts 10 tick intervals.
// Backpressure: tx_start is honoured only while tx_busy is low; tx_busy covers accept through stop bit.
module md5_uart_tx #(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int BAUD          = 12_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       txd,
  output logic       tx_busy
);
  // 32-bit fractional increment for a BAUD-rate tick, rounded to nearest
  localparam logic [31:0] BIT_INC =
    32'(((64'(BAUD) << 32) + 64'(CLK_FREQUENCY / 2)) / 64'(CLK_FREQUENCY));

  logic [31:0] acc_q;
  logic [32:0] acc_sum;
  logic        tick;
  logic [9:0]  shift_q;
  logic [3:0]  bit_q;
  logic        busy_q;

  assign acc_sum = {1'b0, acc_q} + {1'b0, BIT_INC};
  assign tick    = acc_sum[32];
  assign txd     = shift_q[0];
  assign tx_busy = busy_q;

  // Frame shifter: load start/data/stop on accept, shift in idle ones on each bit tick
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q   <= '0;
      shift_q <= '1;
      bit_q   <= '0;
      busy_q  <= 1'b0;
    end else if (tx_start && !busy_q) begin
      acc_q   <= '0;
      shift_q <= {1'b1, tx_data, 1'b0};
      bit_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      acc_q <= acc_sum[31:0];
      if (busy_q && tick) begin
        shift_q <= {1'b1, shift_q[9:1]};
        bit_q   <= bit_q + 4'd1;
        if (bit_q == 4'd9) busy_q <= 1'b0;
      end
    end
  end
endmodule

// md5_uart_top: serial command front end - UART rx -> command parser/test responder -> UART tx, plus LEDs.
// Latency: response starts ~3 clk after the command stop-bit sample; 2 clk idle between response bytes.
// Backpressure: none on rxd; command bytes arriving while a response is in flight are discarded.
module md5_uart_top #(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int BAUD          = 12_000_000,
  parameter int NUM_LEDS      = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rxd,
  output logic                txd,
  output logic                match_led,
  output logic [NUM_LEDS-1:0] led
);
  localparam logic [7:0] CMD_TEST   = 8'h04;
  localparam logic [7:0] RESP_FIRST = 8'h0A;

  typedef enum logic [1:0] {IDLE, DECODE, RESP_LOAD, RESP_WAIT} state_t;

  state_t              state_q, state_d;
  logic [7:0]          cmd_q, cmd_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [NUM_LEDS-1:0] led_q, led_d;
  logic                match_q, match_d;
  logic                rx_valid;
  logic [7:0]          rx_data;
  logic                tx_start;
  logic                tx_busy;

  md5_uart_rx #(.CLK_FREQUENCY(CLK_FREQUENCY), .BAUD(BAUD)) u_rx (
    .clk      (clk),
    .reset    (reset),
    .rxd      (rxd),
    .rx_valid (rx_valid),
    .rx_data  (rx_data)
  );

  md5_uart_tx #(.CLK_FREQUENCY(CLK_FREQUENCY), .BAUD(BAUD)) u_tx (
    .clk      (clk),
    .reset    (reset),
    .tx_start (tx_start),
    .tx_data  (cnt_q),
    .txd      (txd),
    .tx_busy  (tx_busy)
  );

  assign led       = led_q;
  assign match_led = match_q;

  // Parser state and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      cnt_q   <= '0;
      led_q   <= '0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
      match_q <= match_d;
    end
  end

  // Parser next-state: latch command, decode, then stream the countdown 0x0A..0x01
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    cnt_d    = cnt_q;
    led_d    = led_q;
    match_d  = match_q;
    tx_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_valid) begin
          cmd_d   = rx_data;
          led_d   = NUM_LEDS'(rx_data);
          match_d = 1'b0;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (cmd_q == CMD_TEST) begin
          cnt_d   = RESP_FIRST;
          state_d = RESP_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      RESP_LOAD: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          state_d  = RESP_WAIT;
        end
      end
      RESP_WAIT: begin
        if (!tx_busy) begin
          if (cnt_q == 8'd1) begin
            match_d = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d   = cnt_q - 8'd1;
            state_d = RESP_LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_md5_uart_top.sv
// tb_md5_uart_top: directed bench for the UART command front end.
// Drives 8N1 frames on rxd, decodes txd with a bit-timed monitor, checks bytes, LEDs and timing.
// Bounded waits everywhere; a watchdog ends the run if anything stalls.
`timescale 1ns/1ps
module tb_md5_uart_top;
  localparam int  CLK_FREQUENCY = 100_000_000;
  localparam int  BAUD          = 12_000_000;
  localparam int  NUM_LEDS      = 4;
  localparam real BIT_NS        = 1.0e9 / BAUD;

  logic                clk   = 1'b0;
  logic                reset = 1'b1;
  logic                rxd   = 1'b1;
  logic                txd;
  logic                match_led;
  logic [NUM_LEDS-1:0] led;

  int        checks = 0;
  int        errors = 0;
  int        low_cnt;
  logic [7:0] tx_bytes[$];
  realtime    start_t[$];

  md5_uart_top #(
    .CLK_FREQUENCY (CLK_FREQUENCY),
    .BAUD          (BAUD),
    .NUM_LEDS      (NUM_LEDS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rxd       (rxd),
    .txd       (txd),
    .match_led (match_led),
    .led       (led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // txd decoder: records each start edge, samples bits at their centres
  initial begin : tx_monitor
    logic [7:0] b;
    forever begin
      @(negedge txd);
      start_t.push_back($realtime);
      #(BIT_NS / 2.0);
      if (txd === 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          #(BIT_NS);
          b[i] = txd;
        end
        #(BIT_NS);
        if (txd === 1'b1) tx_bytes.push_back(b);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    rxd = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      #(BIT_NS);
    end
    rxd = stop_bit;
    #(BIT_NS);
    rxd = 1'b1;
    #(BIT_NS);
  endtask

  task automatic watch_idle(input int n);
    low_cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (txd !== 1'b1) low_cnt++;
    end
  endtask

  task automatic wait_match(input string tag, output realtime t);
    int n = 0;
    while (match_led !== 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    t = $realtime;
    chk({tag, "_match"}, match_led, 1);
  endtask

  // Sends 0x04 and checks the full 10-byte countdown plus LED and timing behaviour
  task automatic run_cmd04(input string tag);
    realtime t_done;
    realtime span;
    logic    in_range;
    tx_bytes.delete();
    start_t.delete();
    send_byte(8'h04, 1'b1);
    chk({tag, "_led"}, led, 4);
    chk({tag, "_match_low"}, match_led, 0);
    wait_match(tag, t_done);
    chk({tag, "_count"}, tx_bytes.size(), 10);
    for (int i = 0; i < tx_bytes.size() && i < 10; i++)
      chk($sformatf("%s_byte%0d", tag, i), tx_bytes[i], 10 - i);
    if (start_t.size() > 0) begin
      span     = t_done - start_t[0];
      in_range = (span > 8250.0) && (span < 8650.0);
      chk($sformatf("%s_span_%0dns", tag, int'(span)), in_range, 1);
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin : stimulus
    int n;
    // Reset held for 100 cycles, then 100 idle cycles
    reset = 1'b1;
    watch_idle(100);
    chk("rst_txd_low_cycles", low_cnt, 0);
    chk("rst_txd", txd, 1);
    chk("rst_match", match_led, 0);
    chk("rst_led", led, 0);
    reset = 1'b0;
    watch_idle(100);
    chk("idle_txd_low_cycles", low_cnt, 0);
    chk("idle_bytes", tx_bytes.size(), 0);
    chk("idle_led", led, 0);

    // Test command produces the countdown
    run_cmd04("t2");

    // Unknown command: no response, LEDs follow, match cleared
    tx_bytes.delete();
    send_byte(8'h07, 1'b1);
    watch_idle(2000);
    chk("t3_txd_low_cycles", low_cnt, 0);
    chk("t3_bytes", tx_bytes.size(), 0);
    chk("t3_led", led, 7);
    chk("t3_match", match_led, 0);

    // Back-to-back test commands; second one drops match_led while running
    run_cmd04("t4a");
    run_cmd04("t4b");

    // Reset during the 3rd response byte
    tx_bytes.delete();
    start_t.delete();
    send_byte(8'h04, 1'b1);
    n = 0;
    while (start_t.size() < 3 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("t5_third_start", start_t.size(), 3);
    repeat (12) @(negedge clk);
    chk("t5_pre_txd", txd, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("t5_rst_txd", txd, 1);
    chk("t5_rst_match", match_led, 0);
    chk("t5_rst_led", led, 0);
    @(negedge clk);
    reset = 1'b0;
    watch_idle(300);
    chk("t5_post_txd_low_cycles", low_cnt, 0);
    chk("t5_post_match", match_led, 0);
    run_cmd04("t5b");

    // Framing error: bad stop bit is dropped, LEDs unchanged
    send_byte(8'h07, 1'b1);
    repeat (200) @(negedge clk);
    chk("t6_led_pre", led, 7);
    tx_bytes.delete();
    send_byte(8'h04, 1'b0);
    watch_idle(1500);
    chk("t6_txd_low_cycles", low_cnt, 0);
    chk("t6_bytes", tx_bytes.size(), 0);
    chk("t6_led", led, 7);
    chk("t6_match", match_led, 0);
    run_cmd04("t6b");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
